// File: rtl/deq_shifter_if.sv
// rtl/deq_shifter_if.sv - request, BRAM and count-update signals of the QuickQ dequeue engine
interface deq_shifter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              deq_req;
    logic              enq_active;
    logic [ADDR_W:0]   count_in;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              deq_valid;
    logic [DATA_W-1:0] deq_data;
    logic              empty_err;
    logic [ADDR_W:0]   count_out;
    logic              count_we;

    // requester / BRAM / last-index register side
    modport master (
        output deq_req, enq_active, count_in, rd_data,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  busy, deq_valid, deq_data, empty_err, count_out, count_we
    );

    // dequeue engine side
    modport slave (
        input  deq_req, enq_active, count_in, rd_data,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output busy, deq_valid, deq_data, empty_err, count_out, count_we
    );
endinterface

// File: rtl/deq_shifter.sv
// rtl/deq_shifter.sv - QuickQ dequeue engine: pop BRAM head, shift entries down, clear top slot
module deq_shifter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    deq_shifter_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {IDLE, HEAD, SHIFT, DRAIN, CLEAR, FIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   n_m1;
    logic [ADDR_W:0]   i_q;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_pend;
    logic              cap_head;
    logic              empty_q;
    logic [DATA_W-1:0] deq_data_q;
    logic              accept;
    logic              reject;

    assign n_m1          = n_q - ONE;
    assign bus.deq_data  = deq_data_q;
    assign bus.empty_err = empty_q;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and Moore decode of the BRAM ports and completion strobes
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        reject        = 1'b0;
        bus.busy      = (state != IDLE);
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.deq_valid = 1'b0;
        bus.count_we  = 1'b0;
        bus.count_out = '0;
        case (state)
            IDLE: begin
                // the request is still high while the empty error is shown; don't re-answer it
                if (bus.deq_req && !bus.enq_active && !empty_q) begin
                    if (bus.count_in == '0) begin
                        reject = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = HEAD;
                    end
                end
            end
            HEAD: begin
                bus.rd_en = 1'b1;
                state_nxt = (n_q > ONE) ? SHIFT : DRAIN;
            end
            SHIFT: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = i_q[ADDR_W-1:0];
                if (i_q == n_m1) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = CLEAR;
            end
            CLEAR: begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = n_m1[ADDR_W-1:0];
                state_nxt   = FIN;
            end
            FIN: begin
                bus.deq_valid = 1'b1;
                bus.count_we  = 1'b1;
                bus.count_out = n_m1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // a shift read issued last cycle lands one slot lower this cycle
        if (wb_pend) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = wb_addr;
            bus.wr_data = bus.rd_data;
        end
    end

    // count latch, read index, pending write-back and head capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q        <= '0;
            i_q        <= '0;
            wb_pend    <= 1'b0;
            wb_addr    <= '0;
            cap_head   <= 1'b0;
            empty_q    <= 1'b0;
            deq_data_q <= '0;
        end else begin
            if (accept) begin
                n_q <= (bus.count_in > DEPTH) ? DEPTH : bus.count_in;
            end
            empty_q <= reject;
            if (state == HEAD) begin
                i_q <= ONE;
            end else if (state == SHIFT) begin
                i_q <= i_q + ONE;
            end
            wb_pend  <= (state == SHIFT);
            wb_addr  <= i_q[ADDR_W-1:0] - 1'b1;
            cap_head <= (state == HEAD);
            if (cap_head) begin
                deq_data_q <= bus.rd_data;
            end
        end
    end
endmodule

// File: tb/tb_deq_shifter.sv
// tb/tb_deq_shifter.sv - randomized bench for deq_shifter against a pop timeline and BRAM image model
module tb_deq_shifter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    deq_shifter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    deq_shifter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DATA_W-1:0] mem [DEPTH];
    logic              ld_en   = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;

    // BRAM with one-cycle read latency; bench preload uses the write port while the engine idles
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
        else if (ld_en) mem[ld_addr] <= ld_data;
    end

    int                ecnt = 0;
    int                m_t  = 0;
    int                m_n  = 0;
    bit                m_active = 1'b0;
    bit                m_err    = 1'b0;
    logic [DATA_W-1:0] m_pop = '0;
    logic [DATA_W-1:0] snap [DEPTH];
    logic [DATA_W-1:0] img  [DEPTH];
    int                wr_cyc [16];
    int                n_chk  = 0;
    int                n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic model();
        int  k;
        bit  nerr;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 1'b0;
                m_err    = 1'b0;
                m_pop    = '0;
            end else begin
                k    = ecnt - m_t;
                nerr = 1'b0;
                if (m_active) begin
                    if (k == 2) m_pop = snap[0];
                    if (k == m_n + 3) m_active = 1'b0;
                end else if (bus.deq_req && !bus.enq_active && !m_err) begin
                    if (int'(bus.count_in) == 0) begin
                        nerr = 1'b1;
                    end else begin
                        m_active = 1'b1;
                        m_n      = (int'(bus.count_in) > DEPTH) ? DEPTH : int'(bus.count_in);
                        m_t      = ecnt;
                        for (int j = 0; j < DEPTH; j++) snap[j] = mem[j];
                    end
                end
                m_err = nerr;
                ecnt++;
            end
        end
    endtask

    task automatic monitor();
        int                k;
        logic              e_rd;
        logic              e_wr;
        logic              e_end;
        logic [ADDR_W-1:0] e_ra;
        logic [ADDR_W-1:0] e_wa;
        logic [DATA_W-1:0] e_wd;
        logic [127:0]      act;
        logic [127:0]      exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                k    = ecnt - m_t;
                e_rd = m_active && k >= 1 && k <= m_n;
                e_ra = e_rd ? ADDR_W'(k - 1) : '0;
                e_wr = m_active && k >= 3 && k <= m_n + 2;
                e_wa = '0;
                e_wd = '0;
                if (e_wr && k <= m_n + 1) begin
                    e_wa = ADDR_W'(k - 3);
                    e_wd = snap[k - 2];
                end else if (e_wr) begin
                    e_wa = ADDR_W'(m_n - 1);
                end
                e_end = m_active && k == m_n + 3;
                exp = 128'({m_active, e_rd, e_ra, e_wr, e_wa, e_wd, e_end, m_err, e_end,
                            e_end ? (ADDR_W+1)'(m_n - 1) : (ADDR_W+1)'(0), m_pop});
                act = 128'({bus.busy, bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr, bus.wr_data,
                            bus.deq_valid, bus.empty_err, bus.count_we, bus.count_out, bus.deq_data});
                chk($sformatf("cycle_outputs k=%0d", k), act, exp);
            end
        end
    endtask

    task automatic load(input int a, input logic [DATA_W-1:0] v);
        ld_en   = 1'b1;
        ld_addr = ADDR_W'(a);
        ld_data = v;
        img[a]  = v;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    // lat is counted in cycles after the acceptance edge
    task automatic pop(input int h, output int lat, output bit err,
                       output logic [DATA_W-1:0] dd, output logic [ADDR_W:0] co);
        lat = -1;
        err = 1'b0;
        dd  = '0;
        co  = '0;
        for (int i = 0; i < 16; i++) wr_cyc[i] = -1;
        bus.deq_req    = 1'b1;
        bus.enq_active = (h > 0);
        for (int c = 0; c < 1200 + h; c++) begin
            @(negedge clk);
            if (bus.wr_en && bus.wr_addr[ADDR_W-1:4] == '0) wr_cyc[bus.wr_addr[3:0]] = c - h;
            if (bus.deq_valid || bus.empty_err) begin
                lat = c - h;
                err = bus.empty_err;
                dd  = bus.deq_data;
                co  = bus.count_out;
                break;
            end
            @(posedge clk);
            #1;
            if (c + 1 >= h) bus.enq_active = 1'b0;
        end
        if (lat < 0) chk("pop_handshake_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
        bus.deq_req    = 1'b0;
        bus.enq_active = 1'b0;
    endtask

    task automatic pop_and_check(input string tag, input int cnt, input int h, output int lat,
                                 output logic [DATA_W-1:0] dd, output logic [ADDR_W:0] co);
        bit err;
        int n;
        bus.count_in = (ADDR_W+1)'(cnt);
        pop(h, lat, err, dd, co);
        n = (cnt > DEPTH) ? DEPTH : cnt;
        if (n == 0) begin
            chk({tag, " empty_err"}, 128'(err), 128'(1));
            chk({tag, " err_latency"}, 128'(lat), 128'(1));
        end else begin
            chk({tag, " empty_err"}, 128'(err), 128'(0));
            chk({tag, " latency"}, 128'(lat), 128'(n + 3));
            chk({tag, " deq_data"}, 128'(dd), 128'(img[0]));
            chk({tag, " count_out"}, 128'(co), 128'(n - 1));
            for (int j = 0; j < n - 1; j++) img[j] = img[j + 1];
            img[n - 1] = '0;
            for (int j = 0; j < n; j++)
                chk($sformatf("%s bram[%0d]", tag, j), 128'(mem[j]), 128'(img[j]));
        end
    endtask

    task automatic main_seq();
        int                lat;
        int                cnt;
        int                v;
        logic [DATA_W-1:0] dd;
        logic [ADDR_W:0]   co;

        bus.deq_req    = 1'b0;
        bus.enq_active = 1'b0;
        bus.count_in   = '0;
        #1;
        rst = 1'b1;
        #1;
        chk("reset busy", 128'(bus.busy), 128'(0));
        chk("reset outputs", 128'({bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr, bus.wr_data,
                                   bus.deq_valid, bus.empty_err, bus.count_we, bus.count_out,
                                   bus.deq_data}), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // n=3, [5,9,12]
        load(0, 32'd5); load(1, 32'd9); load(2, 32'd12);
        pop_and_check("n3", 3, 0, lat, dd, co);
        chk("n3 lit latency", 128'(lat), 128'(6));
        chk("n3 lit deq_data", 128'(dd), 128'(5));
        chk("n3 lit count_out", 128'(co), 128'(2));
        chk("n3 lit bram", 128'({mem[0], mem[1], mem[2]}), 128'({32'd9, 32'd12, 32'd0}));
        chk("n3 lit write cycles", 128'({wr_cyc[0], wr_cyc[1], wr_cyc[2]}), 128'({32'd3, 32'd4, 32'd5}));

        // n=1, [7]
        load(0, 32'd7);
        pop_and_check("n1", 1, 0, lat, dd, co);
        chk("n1 lit latency", 128'(lat), 128'(4));
        chk("n1 lit deq_data", 128'(dd), 128'(7));
        chk("n1 lit bram0", 128'(mem[0]), 128'(0));
        chk("n1 lit count_out", 128'(co), 128'(0));
        chk("n1 lit writes", 128'({wr_cyc[0], wr_cyc[1]}), 128'({32'd3, -32'sd1}));

        // n=0
        pop_and_check("n0", 0, 0, lat, dd, co);
        chk("n0 lit err_cycle", 128'(lat), 128'(1));

        // enqueue owns BRAM for 5 cycles while the request is held
        load(0, 32'd30); load(1, 32'd31); load(2, 32'd40);
        pop_and_check("enq", 3, 5, lat, dd, co);
        chk("enq lit latency", 128'(lat), 128'(6));
        chk("enq lit deq_data", 128'(dd), 128'(30));

        // full ascending ramp, then a saturating count
        for (int j = 0; j < DEPTH; j++) load(j, 32'(j * 7 + 100));
        pop_and_check("ramp", DEPTH, 0, lat, dd, co);
        chk("ramp lit deq_data", 128'(dd), 128'(100));
        chk("ramp lit count_out", 128'(co), 128'(1023));
        chk("ramp lit top_slot", 128'(mem[1023]), 128'(0));
        pop_and_check("sat", 2000, 0, lat, dd, co);
        chk("sat lit deq_data", 128'(dd), 128'(107));
        chk("sat lit count_out", 128'(co), 128'(1023));

        // reset in cycle 2 of an n=4 pop
        for (int j = 0; j < 4; j++) load(j, 32'(20 + j));
        bus.count_in = (ADDR_W+1)'(4);
        bus.deq_req  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst shifting", 128'({bus.busy, bus.rd_en, bus.rd_addr}), 128'({1'b1, 1'b1, 10'd1}));
        rst = 1'b1;
        #1;
        chk("mid_rst busy", 128'(bus.busy), 128'(0));
        chk("mid_rst outputs", 128'({bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr, bus.wr_data,
                                     bus.deq_valid, bus.empty_err, bus.count_we, bus.count_out,
                                     bus.deq_data}), 128'(0));
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.deq_req = 1'b0;
        pop_and_check("after_rst", 4, 0, lat, dd, co);
        chk("after_rst lit deq_data", 128'(dd), 128'(20));

        // randomized pops, some back-to-back without reload
        cnt = 0;
        for (int it = 0; it < 30; it++) begin
            if (cnt == 0 || $urandom_range(0, 2) == 0) begin
                cnt = int'($urandom_range(0, 20));
                v   = int'($urandom_range(0, 1000));
                for (int j = 0; j < cnt; j++) begin
                    v = v + int'($urandom_range(1, 50));
                    load(j, 32'(v));
                end
            end
            pop_and_check($sformatf("rand%0d", it), cnt, int'($urandom_range(0, 3)), lat, dd, co);
            if (cnt > 0) cnt--;
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        fork
            model();
            monitor();
            main_seq();
        join_any
        disable fork;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
